// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner producing one debounced hex code per press
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int SETTLE   = 1000,
  parameter int DEBOUNCE = 100000,
  parameter int REPEAT   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       pressed
);

  localparam int CNT_MAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  state_t        state, state_next;
  logic [3:0]    row_meta, row_s;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    c_idx, c_idx_next;
  logic [1:0]    r_idx, r_idx_next;
  logic [1:0]    low_row;
  logic [3:0]    key_next;
  logic          key_valid_next;
  logic          pressed_next;
  logic          settle_done, deb_done, any_low, row_hit;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT - 1);
  logic [RW-1:0] rpt_cnt, rpt_next;
`else
  localparam int repeat_unused = REPEAT;
`endif

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign settle_done = (cnt == SETTLE_LAST);
  assign deb_done    = (cnt == DEB_LAST);
  assign any_low     = (row_s != 4'hF);
  assign row_hit     = ~row_s[r_idx];

  // Lowest-index low row wins when several rows in a column are down.
  always_comb begin
    low_row = 2'd3;
    if (!row_s[2]) low_row = 2'd2;
    if (!row_s[1]) low_row = 2'd1;
    if (!row_s[0]) low_row = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_SCAN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_SCAN:     if (settle_done && any_low) state_next = S_DEBOUNCE;
      S_DEBOUNCE: if (!row_hit) state_next = S_SCAN;
                  else if (deb_done) state_next = S_HELD;
      S_HELD:     if (!row_hit) state_next = S_RELEASE;
      S_RELEASE:  if (!row_hit && deb_done) state_next = S_SCAN;
      default:    state_next = S_SCAN;
    endcase
  end

  always_comb begin
    cnt_next       = cnt;
    c_idx_next     = c_idx;
    r_idx_next     = r_idx;
    key_next       = key;
    key_valid_next = 1'b0;
    pressed_next   = pressed;
`ifdef KEYPAD_REPEAT_EN
    rpt_next       = rpt_cnt;
`endif
    case (state)
      S_SCAN: begin
        if (settle_done) begin
          cnt_next = '0;
          if (any_low) r_idx_next = low_row;
          else         c_idx_next = c_idx - 2'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (!row_hit) begin
          cnt_next = '0;
        end else if (deb_done) begin
          cnt_next       = '0;
          key_valid_next = 1'b1;
          key_next       = key_code(r_idx, c_idx);
          pressed_next   = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rpt_next       = '0;
`endif
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!row_hit) begin
          cnt_next = '0;
`ifdef KEYPAD_REPEAT_EN
          rpt_next = '0;
        end else if (rpt_cnt == RPT_LAST) begin
          key_valid_next = 1'b1;
          rpt_next       = '0;
        end else begin
          rpt_next = rpt_cnt + 1'b1;
`endif
        end
      end
      S_RELEASE: begin
        // Any bounce back to low restarts the release run.
        if (row_hit) begin
          cnt_next = '0;
        end else if (deb_done) begin
          cnt_next     = '0;
          pressed_next = 1'b0;
          c_idx_next   = c_idx - 2'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta  <= 4'hF;
      row_s     <= 4'hF;
      cnt       <= '0;
      c_idx     <= 2'd3;
      r_idx     <= 2'd0;
      col       <= 4'b0111;
      key       <= 4'h0;
      key_valid <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      row_meta  <= row;
      row_s     <= row_meta;
      cnt       <= cnt_next;
      c_idx     <= c_idx_next;
      r_idx     <= r_idx_next;
      col       <= ~(4'b0001 << c_idx_next);
      key       <= key_next;
      key_valid <= key_valid_next;
      pressed   <= pressed_next;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) rpt_cnt <= '0;
    else       rpt_cnt <= rpt_next;
  end
`endif

endmodule
